// File: rtl/nts_tx_buffer.sv
// Single-packet transmit buffer for the NTS engine.
// Words are written in, committed on last, then drained through a FWFT read port.
module nts_tx_buffer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_areset,
    output logic        o_busy,
    input  logic        i_write_en,
    input  logic [63:0] i_write_data,
    input  logic        i_write_last,
    input  logic [7:0]  i_write_data_valid,
    output logic        o_error_overflow,
    output logic        o_error_write_busy,
    output logic        o_packet_available,
    input  logic        i_packet_read_discard,
    output logic [7:0]  o_data_valid,
    output logic        o_fifo_empty,
    input  logic        i_fifo_rd_en,
    output logic [63:0] o_fifo_rd_data
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_WRITE,
        S_PREFETCH,
        S_READY,
        S_ERROR_OVERFLOW
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]            mask_q, mask_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_busy_q, err_busy_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [63:0]           mem [0:(1<<ADDR_WIDTH)-1];
    logic [63:0]           rd_data_q;
    logic                  not_empty;

    assign not_empty = (state_q == S_READY) && (rd_ptr_q < word_count_q);

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        rd_ptr_d     = rd_ptr_q;
        mask_d       = mask_q;
        err_ovf_d    = 1'b0;
        err_busy_d   = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wr_addr_q;
        mem_raddr    = rd_ptr_q[ADDR_WIDTH-1:0];
        unique case (state_q)
            S_EMPTY: begin
                mem_waddr = '0;
                if (i_write_en) begin
                    mem_we = 1'b1;
                    if (i_write_last) begin
                        word_count_d = (ADDR_WIDTH+1)'(1);
                        mask_d       = i_write_data_valid;
                        state_d      = S_PREFETCH;
                    end else begin
                        wr_addr_d = ADDR_WIDTH'(1);
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (i_write_en) begin
                    mem_we = 1'b1;
                    if (i_write_last) begin
                        word_count_d = {1'b0, wr_addr_q} + (ADDR_WIDTH+1)'(1);
                        mask_d       = i_write_data_valid;
                        wr_addr_d    = '0;
                        state_d      = S_PREFETCH;
                    end else if (&wr_addr_q) begin
                        wr_addr_d = '0;
                        err_ovf_d = 1'b1;
                        state_d   = S_ERROR_OVERFLOW;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_ERROR_OVERFLOW: begin
                if (i_write_en && i_write_last) begin
                    state_d = S_EMPTY;
                end
            end
            S_PREFETCH: begin
                mem_raddr  = '0;
                rd_ptr_d   = '0;
                err_busy_d = i_write_en;
                state_d    = S_READY;
            end
            S_READY: begin
                err_busy_d = i_write_en;
                // Discard beats a simultaneous pop.
                if (i_packet_read_discard) begin
                    rd_ptr_d = '0;
                    state_d  = S_EMPTY;
                end else if (i_fifo_rd_en && not_empty) begin
                    rd_ptr_d  = rd_ptr_q + (ADDR_WIDTH+1)'(1);
                    mem_raddr = rd_ptr_d[ADDR_WIDTH-1:0];
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q      <= S_EMPTY;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            rd_ptr_q     <= '0;
            mask_q       <= '0;
            err_ovf_q    <= 1'b0;
            err_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            word_count_q <= word_count_d;
            rd_ptr_q     <= rd_ptr_d;
            mask_q       <= mask_d;
            err_ovf_q    <= err_ovf_d;
            err_busy_q   <= err_busy_d;
        end
    end

    // Plain BRAM: registered read of the word at the next read pointer.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= i_write_data;
        end
        rd_data_q <= mem[mem_raddr];
    end

    assign o_busy             = (state_q != S_EMPTY);
    assign o_packet_available = (state_q == S_READY);
    assign o_data_valid       = o_packet_available ? mask_q : 8'h00;
    assign o_fifo_empty       = !not_empty;
    assign o_fifo_rd_data     = not_empty ? rd_data_q : 64'h0;
    assign o_error_overflow   = err_ovf_q;
    assign o_error_write_busy = err_busy_q;

endmodule

// File: tb/tb_nts_tx_buffer.sv
// Self-checking bench for nts_tx_buffer with an 8-word buffer.
// A queue holds the words of the packet in flight as the reference.
module tb_nts_tx_buffer;

    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        areset;
    logic        busy;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        wr_last;
    logic [7:0]  wr_valid;
    logic        err_ovf;
    logic        err_wbusy;
    logic        avail;
    logic        discard;
    logic [7:0]  dvalid;
    logic        empty;
    logic        rd_en;
    logic [63:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    nts_tx_buffer #(.ADDR_WIDTH(AW)) dut (
        .i_clk                 (clk),
        .i_areset              (areset),
        .o_busy                (busy),
        .i_write_en            (wr_en),
        .i_write_data          (wr_data),
        .i_write_last          (wr_last),
        .i_write_data_valid    (wr_valid),
        .o_error_overflow      (err_ovf),
        .o_error_write_busy    (err_wbusy),
        .o_packet_available    (avail),
        .i_packet_read_discard (discard),
        .o_data_valid          (dvalid),
        .o_fifo_empty          (empty),
        .i_fifo_rd_en          (rd_en),
        .o_fifo_rd_data        (rd_data)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_avail"}, avail, 1'b0);
        chk1({tag, "_empty"}, empty, 1'b1);
        chk64({tag, "_rd_data"}, rd_data, 64'h0);
        chk8({tag, "_dvalid"}, dvalid, 8'h00);
        chk1({tag, "_err_ovf"}, err_ovf, 1'b0);
        chk1({tag, "_err_wbusy"}, err_wbusy, 1'b0);
    endtask

    task automatic write_pkt(input int n, input logic [7:0] mask, input bit gaps);
        logic [63:0] w;
        exp_q.delete();
        chk1("busy_before_write", busy, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            exp_q.push_back(w);
            wr_en    = 1'b1;
            wr_data  = w;
            wr_last  = (i == n - 1);
            wr_valid = (i == n - 1) ? mask : 8'($urandom);
            cyc();
            wr_en   = 1'b0;
            wr_last = 1'b0;
            if (i == 0) chk1("busy_after_first", busy, 1'b1);
            if (gaps && i < n - 1) repeat ($urandom_range(0, 2)) cyc();
        end
        chk1("avail_in_prefetch", avail, 1'b0);
        cyc();
        chk1("avail", avail, 1'b1);
        chk8("mask", dvalid, mask);
        chk1("not_empty", empty, 1'b0);
        chk1("no_ovf", err_ovf, 1'b0);
    endtask

    task automatic read_pkt(input bit gaps);
        int k = 0;
        int guard = 0;
        while (k < exp_q.size() && guard < 200) begin
            rd_en = !gaps || ($urandom_range(0, 1) == 1);
            chk1("rd_not_empty", empty, 1'b0);
            chk64("rd_data", rd_data, exp_q[k]);
            cyc();
            if (rd_en) k++;
            guard++;
        end
        rd_en = 1'b0;
        chk8("read_count", 8'(k), 8'(exp_q.size()));
        chk1("empty_after_read", empty, 1'b1);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk1("empty_rd_ignored", empty, 1'b1);
        chk1("avail_after_read", avail, 1'b1);
    endtask

    task automatic do_discard();
        discard = 1'b1;
        cyc();
        discard = 1'b0;
        chk1("disc_avail", avail, 1'b0);
        chk1("disc_empty", empty, 1'b1);
        chk1("disc_busy", busy, 1'b0);
    endtask

    initial begin
        int ovf_cnt;
        int av_seen;
        logic [7:0] m;

        areset   = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        wr_valid = '0;
        discard  = 1'b0;
        rd_en    = 1'b0;
        cyc();
        cyc();
        areset = 1'b0;
        cyc();
        check_reset_outputs("reset");

        // six-word packet, partial last word
        write_pkt(6, 8'h0f, 1'b0);
        read_pkt(1'b0);
        do_discard();

        // single-word packet
        write_pkt(1, 8'hff, 1'b0);
        read_pkt(1'b0);
        do_discard();

        // exactly full buffer
        write_pkt(8, 8'h01, 1'b0);
        read_pkt(1'b0);
        do_discard();

        // one word too many
        ovf_cnt = 0;
        av_seen = 0;
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_data = {$urandom, $urandom};
            wr_last = (i == 8);
            wr_valid = 8'hff;
            cyc();
            ovf_cnt += int'(err_ovf);
            av_seen += int'(avail);
        end
        wr_en   = 1'b0;
        wr_last = 1'b0;
        repeat (3) begin
            cyc();
            ovf_cnt += int'(err_ovf);
            av_seen += int'(avail);
        end
        chk8("ovf_pulses", 8'(ovf_cnt), 8'd1);
        chk8("ovf_no_avail", 8'(av_seen), 8'd0);
        chk1("ovf_busy_clear", busy, 1'b0);
        write_pkt(5, 8'h3f, 1'b0);
        read_pkt(1'b0);
        do_discard();

        // partial read, then pop and discard together
        write_pkt(4, 8'hff, 1'b0);
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk64("partial_rd", rd_data, exp_q[i]);
            cyc();
        end
        discard = 1'b1;
        cyc();
        rd_en   = 1'b0;
        discard = 1'b0;
        chk1("rd_disc_avail", avail, 1'b0);
        chk1("rd_disc_empty", empty, 1'b1);
        chk1("rd_disc_busy", busy, 1'b0);
        write_pkt(3, 8'h07, 1'b0);
        read_pkt(1'b0);
        do_discard();

        // write while packet held
        write_pkt(5, 8'h7f, 1'b0);
        wr_en   = 1'b1;
        wr_data = {$urandom, $urandom};
        cyc();
        wr_en = 1'b0;
        chk1("wbusy_pulse", err_wbusy, 1'b1);
        cyc();
        chk1("wbusy_end", err_wbusy, 1'b0);
        chk8("wbusy_mask_kept", dvalid, 8'h7f);
        read_pkt(1'b0);
        wr_en   = 1'b1;
        discard = 1'b1;
        cyc();
        wr_en   = 1'b0;
        discard = 1'b0;
        chk1("wbusy_on_discard", err_wbusy, 1'b1);
        chk1("discard_with_write_busy", busy, 1'b0);
        cyc();
        chk1("write_dropped_busy", busy, 1'b0);

        // reset mid-write
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = {$urandom, $urandom};
            cyc();
        end
        wr_en  = 1'b0;
        areset = 1'b1;
        cyc();
        areset = 1'b0;
        check_reset_outputs("rst_write");
        write_pkt(2, 8'h03, 1'b0);
        read_pkt(1'b0);
        do_discard();

        // reset mid-read
        write_pkt(4, 8'hff, 1'b0);
        rd_en = 1'b1;
        cyc();
        rd_en  = 1'b0;
        areset = 1'b1;
        cyc();
        areset = 1'b0;
        check_reset_outputs("rst_read");
        write_pkt(2, 8'h1f, 1'b0);
        read_pkt(1'b0);
        do_discard();

        // random lengths, masks and gaps
        repeat (8) begin
            m = 8'hff >> $urandom_range(0, 7);
            write_pkt($urandom_range(1, 8), m, 1'b1);
            read_pkt(1'b1);
            do_discard();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nts_tx_buffer.md
Name: nts_tx_buffer

Overview:
- Transmit-side packet buffer for the NTS engine. The engine writes a response packet into it as 64-bit words.
- Once the packet is committed, the block presents it to the TX dispatcher/MAC through a first-word-fall-through FIFO read interface: packet_available, fifo_empty, rd_en, rd_data, data_valid, read_discard.
- That read interface mirrors the interface the engine consumes on the receive side. One packet is held at a time, in internal BRAM of 2^ADDR_WIDTH x 64.

Parameters:
ADDR_WIDTH, 10, log2 of buffer depth in 64-bit words

Ports:
i_clk  in  1  clock
i_areset  in  1  reset, synchronous, active-high
o_busy  out  1  high from first accepted write until packet discarded
i_write_en  in  1  engine writes i_write_data this cycle
i_write_data  in  64  packet word, big-endian byte order
i_write_last  in  1  qualifies i_write_en: final word of packet
i_write_data_valid  in  8  byte mask of last word, sampled with last (ff=8B, 7f=7B, ..., 01=1B)
o_error_overflow  out  1  one-cycle pulse: packet exceeded buffer, dropped
o_error_write_busy  out  1  one-cycle pulse: write attempted while packet held
o_packet_available  out  1  committed packet held for transmit
i_packet_read_discard  in  1  consumer releases packet (done or abort)
o_data_valid  out  8  last-word byte mask of held packet, stable while available
o_fifo_empty  out  1  no unread words remain
i_fifo_rd_en  in  1  pop current word
o_fifo_rd_data  out  64  current word (FWFT)

Behaviour:
- Reset (sync, i_areset=1 at posedge): state EMPTY, all pointers/counters 0.
  - Outputs after reset: o_busy=0, o_packet_available=0, o_fifo_empty=1, o_fifo_rd_data=0, o_data_valid=0, both error pulses 0.
  - Reset mid-packet (writing or reading) discards the packet.
- States: EMPTY, WRITE, PREFETCH, READY, ERROR_OVERFLOW.
- EMPTY:
  - wr_addr=0.
  - On i_write_en: store word at 0, o_busy<=1.
  - With i_write_last: word_count<=1, capture mask, go PREFETCH.
  - Without i_write_last: wr_addr<=1, go WRITE.
- WRITE:
  - On i_write_en: store at wr_addr.
  - With last: word_count<=wr_addr+1 (ADDR_WIDTH+1 bits, so a full 2^ADDR_WIDTH-word packet is legal), capture mask, go PREFETCH.
  - Without last at wr_addr==all-ones: go ERROR_OVERFLOW.
  - Otherwise wr_addr<=wr_addr+1.
  - Idle cycles allowed between writes.
- ERROR_OVERFLOW:
  - Pulse o_error_overflow once on entry.
  - Drop all writes until one with i_write_last, then go EMPTY, o_busy<=0.
  - No packet is ever made available.
- PREFETCH: one cycle; BRAM read of word 0; go READY.
- READY:
  - o_packet_available=1; o_data_valid=captured mask.
  - o_fifo_empty=0 while rd_ptr<word_count.
  - o_fifo_rd_data = word[rd_ptr] (FWFT).
  - i_fifo_rd_en with !o_fifo_empty: rd_ptr<=rd_ptr+1; next word visible on the following cycle.
  - rd_en may be held high every cycle (full throughput, one word/cycle).
  - o_fifo_empty rises the cycle after the last word is popped.
  - rd_en while empty is ignored, no pointer change.
- Discard:
  - i_packet_read_discard in READY (before or after all words read): next cycle state EMPTY, o_packet_available=0, o_fifo_empty=1, o_busy=0, rd_ptr=0.
  - Discard in any other state is ignored.
  - Simultaneous rd_en+discard: discard wins.
- Write while packet held (PREFETCH/READY): word dropped, o_error_write_busy pulses 1 cycle, held packet unaffected.
- Write in the same cycle as discard: dropped with error pulse; the engine must wait for o_busy=0.
- o_busy stays 0 in EMPTY and goes 1 the cycle after the first accepted write.

Test Plan:
1. Write 6 words D0..D5, last with mask 8'h0f.
   - o_packet_available=1 two cycles after last.
   - o_data_valid=0f.
   - rd_en held 6 cycles returns D0..D5 in order.
   - o_fifo_empty=1 after sixth pop.
   - Discard, then o_busy=0.
2. Single-word packet (write_en+last on first word, mask ff): available, one pop, empty; discard returns to EMPTY.
3. ADDR_WIDTH=3:
   - 8 words with last on the 8th are accepted, word_count=8, all read back.
   - 9 words: o_error_overflow pulses once, no packet_available, next packet accepted normally.
4. Held packet of 4 words:
   - Pop 2 words.
   - Assert rd_en+discard simultaneously: packet dropped, no pointer advance visible.
   - New 3-word packet reads back from word 0.
5. While READY, issue i_write_en: o_error_write_busy=1 for one cycle, and held data still reads back intact.
6. Assert i_areset mid-WRITE and mid-READ: next cycle all outputs at reset values; a subsequent 2-word packet transfers correctly.
